// File: rtl/stage2_decode_queue_pkg.sv
// Shared decode definitions: field widths, operand-use and functional-unit
// codes, immediate format codes and the queue entry layout. The format
// decoders import this package too, so codes must stay in sync with them.
package stage2_decode_queue_pkg;

    localparam int REG_WIDTH     = 5;
    localparam int IMM_WIDTH     = 16;
    localparam int IMM_OUT_WIDTH = 64;
    localparam int DQ_WIDTH      = 12;
    localparam int DQ_SHIFT      = 4;
    localparam int DEPTH         = 4;
    localparam int PTR_WIDTH     = $clog2(DEPTH);
    localparam int CNT_WIDTH     = PTR_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL    = CNT_WIDTH'(DEPTH);
    // Stall one entry early: the decoder pipeline may already hold one op.
    localparam logic [CNT_WIDTH-1:0] STALL_LEVEL = CNT_WIDTH'(DEPTH - 1);

    localparam logic SIGNED_IMM   = 1'b1;
    localparam logic UNSIGNED_IMM = 1'b0;

    typedef enum logic [1:0] {
        REG_IMM        = 2'd0,
        REG_READ       = 2'd1,
        REG_WRITE      = 2'd2,
        REG_READ_WRITE = 2'd3
    } reg_use_e;

    typedef enum logic [2:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_LDST   = 3'd2,
        FU_BRANCH = 3'd3,
        FU_TRAP   = 3'd4
    } fu_code_e;

    // One queued op; the immediate is stored already completed.
    typedef struct packed {
        logic [REG_WIDTH-1:0]     reg1;
        logic [REG_WIDTH-1:0]     reg2;
        logic [REG_WIDTH-1:0]     reg3;
        logic [1:0]               reg1_use;
        logic [1:0]               reg2_use;
        logic [1:0]               reg3_use;
        logic                     op_bit;
        logic [2:0]               fu_code;
        logic [IMM_OUT_WIDTH-1:0] imm;
    } entry_t;

    // Sign-extend a DQ displacement field to the full immediate width.
    function automatic logic [IMM_OUT_WIDTH-1:0] sign_extend_dq(
        input logic [DQ_WIDTH-1:0] field
    );
        return {{(IMM_OUT_WIDTH - DQ_WIDTH){field[DQ_WIDTH-1]}}, field};
    endfunction

    // Sign- or zero-extend a 16-bit immediate to the full width.
    function automatic logic [IMM_OUT_WIDTH-1:0] extend_imm(
        input logic [IMM_WIDTH-1:0] imm,
        input logic                 is_signed
    );
        logic fill;
        fill = is_signed & imm[IMM_WIDTH-1];
        return {{(IMM_OUT_WIDTH - IMM_WIDTH){fill}}, imm};
    endfunction

endpackage

// File: rtl/stage2_decode_queue_imm_completer.sv
// Immediate completion: turns the right-justified decoder immediate into the
// 64-bit value dispatch consumes. DQ fields (low 12 bits of imm_i) are
// sign-extended and scaled by 16; otherwise signed/unsigned extension applies.
module imm_completer
    import stage2_decode_queue_pkg::*;
(
    input  logic [IMM_WIDTH-1:0]     imm_i,
    input  logic                     imm_format_i,
    input  logic                     imm_is_dq_i,
    output logic [IMM_OUT_WIDTH-1:0] imm_o
);

    // Select DQ scaling or plain extension; DQ ignores the format bit.
    always_comb begin
        imm_o = '0;
        if (imm_is_dq_i) begin
            imm_o = sign_extend_dq(imm_i[DQ_WIDTH-1:0]) << DQ_SHIFT;
        end else begin
            case (imm_format_i)
                SIGNED_IMM:   imm_o = extend_imm(imm_i, 1'b1);
                UNSIGNED_IMM: imm_o = extend_imm(imm_i, 1'b0);
                default:      imm_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/stage2_decode_queue.sv
// Stage-2 decode queue: completes immediates from the format decoders,
// buffers ops in a small FIFO and hands the head entry to dispatch through a
// valid/ready handshake. All outputs come straight from flops; the head
// register is loaded with the entry that will be at the head next cycle.
module stage2_decode_queue
    import stage2_decode_queue_pkg::*;
(
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [REG_WIDTH-1:0]     reg1_i,
    input  logic [REG_WIDTH-1:0]     reg2_i,
    input  logic [REG_WIDTH-1:0]     reg3_i,
    input  logic [1:0]               reg1Use_i,
    input  logic [1:0]               reg2Use_i,
    input  logic [1:0]               reg3Use_i,
    input  logic [IMM_WIDTH-1:0]     imm_i,
    input  logic                     immFormat_i,
    input  logic                     immIsDQ_i,
    input  logic                     bit_i,
    input  logic [2:0]               functionalUnitCode_i,
    output logic                     stall_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [REG_WIDTH-1:0]     reg1_o,
    output logic [REG_WIDTH-1:0]     reg2_o,
    output logic [REG_WIDTH-1:0]     reg3_o,
    output logic [1:0]               reg1Use_o,
    output logic [1:0]               reg2Use_o,
    output logic [1:0]               reg3Use_o,
    output logic                     bit_o,
    output logic [2:0]               functionalUnitCode_o,
    output logic [IMM_OUT_WIDTH-1:0] imm_o,
    output logic                     overflow_o
);

    logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]     count_q, count_d;
    logic                     valid_q, valid_d;
    logic                     stall_q, stall_d;
    logic                     overflow_q, overflow_d;
    entry_t                   head_q, head_d;
    entry_t                   entry_in;
    entry_t                   mem_q [DEPTH];
    logic [IMM_OUT_WIDTH-1:0] imm_full;
    logic                     full;
    logic                     pop;
    logic                     push;

    imm_completer u_imm_completer (
        .imm_i        (imm_i),
        .imm_format_i (immFormat_i),
        .imm_is_dq_i  (immIsDQ_i),
        .imm_o        (imm_full)
    );

    // Assemble the incoming op into an entry with its completed immediate.
    always_comb begin
        entry_in          = '0;
        entry_in.reg1     = reg1_i;
        entry_in.reg2     = reg2_i;
        entry_in.reg3     = reg3_i;
        entry_in.reg1_use = reg1Use_i;
        entry_in.reg2_use = reg2Use_i;
        entry_in.reg3_use = reg3Use_i;
        entry_in.op_bit   = bit_i;
        entry_in.fu_code  = functionalUnitCode_i;
        entry_in.imm      = imm_full;
    end

    // Handshake: a pop frees a slot in the same cycle, so full+pop still pushes.
    always_comb begin
        full = (count_q == CNT_FULL);
        pop  = valid_q & ready_i;
        push = enable_i & (~full | pop);
    end

    // Pointer/count update and selection of the next head entry.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        head_d     = head_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        valid_d    = (count_d != '0);
        stall_d    = (count_d >= STALL_LEVEL);
        overflow_d = enable_i & full & ~pop;

        // The new op becomes head only when it is the sole remaining entry;
        // it is not in storage yet, so take it straight from the input.
        // With nothing left the head register keeps its last value.
        if (valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = entry_in;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers, cleared asynchronously.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    // Entry storage; not reset, only entries behind valid pointers are read.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    assign valid_o              = valid_q;
    assign stall_o              = stall_q;
    assign overflow_o           = overflow_q;
    assign reg1_o               = head_q.reg1;
    assign reg2_o               = head_q.reg2;
    assign reg3_o               = head_q.reg3;
    assign reg1Use_o            = head_q.reg1_use;
    assign reg2Use_o            = head_q.reg2_use;
    assign reg3Use_o            = head_q.reg3_use;
    assign bit_o                = head_q.op_bit;
    assign functionalUnitCode_o = head_q.fu_code;
    assign imm_o                = head_q.imm;

endmodule
